// File: rtl/shapool_result_ctrl.sv
// Job sequencer between the hasher pool and the external IO block: holds the pool
// in reset while idle, releases it after a settle delay, and latches the first win or exhaustion.
module shapool_result_ctrl #(
  parameter int                     RESET_HOLD  = 4,
  parameter int                     COUNT_WIDTH = 40,
  parameter logic [COUNT_WIDTH-1:0] MAX_CYCLES  = 40'hFF_FFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_start,
  input  logic                   result_ack,
  input  logic                   success,
  input  logic [31:0]            nonce,
  input  logic [7:0]             match_flags,
  output logic                   core_reset_n,
  output logic                   ready,
  output logic                   found,
  output logic                   exhausted,
  output logic [39:0]            result,
  output logic [COUNT_WIDTH-1:0] run_count
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(RESET_HOLD - 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_RUN  = MAX_CYCLES - 1'b1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      result       <= '0;
      run_count    <= '0;
      hold         <= '0;
    end else if (job_start) begin
      // A new job load restarts the sequence from any state.
      state        <= PRIME;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      result       <= '0;
      run_count    <= '0;
      hold         <= HOLD_LOAD;
    end else begin
      case (state)
        IDLE: begin
          core_reset_n <= 1'b0;
          ready        <= 1'b0;
        end
        PRIME: begin
          if (hold == '0) begin
            state        <= RUN;
            core_reset_n <= 1'b1;
          end else begin
            hold <= hold - 1'b1;
          end
        end
        RUN: begin
          // A win in the final watchdog cycle still counts as a win.
          if (success) begin
            state        <= DONE;
            result       <= {match_flags, nonce};
            found        <= 1'b1;
            ready        <= 1'b1;
            core_reset_n <= 1'b0;
          end else if (run_count == LAST_RUN) begin
            state        <= DONE;
            exhausted    <= 1'b1;
            ready        <= 1'b1;
            core_reset_n <= 1'b0;
          end else if (run_count != '1) begin
            run_count <= run_count + 1'b1;
          end
        end
        DONE: begin
          core_reset_n <= 1'b0;
          if (result_ack) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shapool_result_ctrl.sv
// Randomized scoreboard bench for shapool_result_ctrl against a job-timeline reference model.
module tb_shapool_result_ctrl;
  localparam int          RH = 4;
  localparam int          CW = 40;
  localparam logic [39:0] MC = 40'd16;

  logic          clk = 1'b0;
  logic          reset, job_start, result_ack, success;
  logic [31:0]   nonce;
  logic [7:0]    match_flags;
  logic          core_reset_n, ready, found, exhausted;
  logic [39:0]   result;
  logic [CW-1:0] run_count;

  shapool_result_ctrl #(.RESET_HOLD(RH), .COUNT_WIDTH(CW), .MAX_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .job_start(job_start), .result_ack(result_ack),
    .success(success), .nonce(nonce), .match_flags(match_flags),
    .core_reset_n(core_reset_n), .ready(ready), .found(found), .exhausted(exhausted),
    .result(result), .run_count(run_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        crn, rdy, fnd, exh;
    logic [39:0] res;
    logic [39:0] rc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a job is a timeline measured in cycles since job_start.
  bit          m_job;
  int          m_age;
  bit          m_rdy, m_fnd, m_exh;
  logic [39:0] m_res, m_rc;

  task automatic step_model(input bit r, js, ack, sc, input logic [31:0] n, input logic [7:0] f);
    if (r) begin
      m_job = 0; m_age = 0; m_rdy = 0; m_fnd = 0; m_exh = 0; m_res = '0; m_rc = '0;
    end else if (js) begin
      m_job = 1; m_age = 0; m_rdy = 0; m_fnd = 0; m_exh = 0; m_res = '0; m_rc = '0;
    end else if (m_job) begin
      if (m_age >= RH) begin
        if (sc) begin
          m_res = {f, n}; m_fnd = 1; m_rdy = 1; m_job = 0;
        end else if (m_rc + 1 == MC) begin
          m_exh = 1; m_rdy = 1; m_job = 0;
        end else if (m_rc != '1) begin
          m_rc = m_rc + 1;
        end
      end else begin
        m_age = m_age + 1;
      end
    end else if (m_rdy && ack) begin
      m_rdy = 0;
    end
  endtask

  task automatic cyc(input bit r, js, ack, sc, input logic [31:0] n, input logic [7:0] f);
    exp_t e;
    reset = r; job_start = js; result_ack = ack; success = sc; nonce = n; match_flags = f;
    @(posedge clk);
    #1;
    step_model(r, js, ack, sc, n, f);
    e.crn = m_job && (m_age >= RH);
    e.rdy = m_rdy; e.fnd = m_fnd; e.exh = m_exh; e.res = m_res; e.rc = m_rc;
    sb.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, $urandom, 8'($urandom));
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents its registered outputs; compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("core_reset_n", 40'(core_reset_n), 40'(e.crn));
        check("ready",        40'(ready),        40'(e.rdy));
        check("found",        40'(found),        40'(e.fnd));
        check("exhausted",    40'(exhausted),    40'(e.exh));
        check("result",       result,            e.res);
        check("run_count",    run_count,         e.rc);
      end
    end
  end

  initial begin
    int b;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
    // success and ack while idle are ignored
    cyc(0, 0, 1, 1, 32'hCAFEF00D, 8'h11);
    idle(2);

    // release timing, then two wins back to back: only the first is kept
    cyc(0, 1, 0, 0, 0, 0);
    idle(RH + 3);
    cyc(0, 0, 0, 1, 32'hDEADBEEF, 8'h02);
    cyc(0, 0, 0, 1, 32'h12345678, 8'hAB);
    idle(3);
    cyc(0, 0, 1, 0, 0, 0);
    idle(2);

    // watchdog exhaustion
    cyc(0, 1, 0, 0, 0, 0);
    b = 0;
    while (!m_rdy && b < 100) begin idle(1); b++; end
    idle(2);
    // job_start beats result_ack in DONE
    cyc(0, 1, 1, 0, 0, 0);

    // win on the last watchdog cycle
    b = 0;
    while (!(m_job && m_age >= RH && m_rc == MC - 1) && b < 100) begin idle(1); b++; end
    cyc(0, 0, 0, 1, 32'h0BADCAFE, 8'h80);
    idle(2);
    cyc(0, 0, 1, 0, 0, 0);

    // reset mid-run, then a stray win with no job
    cyc(0, 1, 0, 0, 0, 0);
    b = 0;
    while (m_rc != 7 && b < 100) begin idle(1); b++; end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h55AA55AA, 8'h7E);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0),
          $urandom, 8'($urandom));

    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 40'(sb.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/shapool_result_ctrl.md
Name: shapool_result_ctrl

Overview:
- Sits directly downstream of the hasher pool, between it and the external IO block.
- Sequences one hashing job:
  - holds the pool in reset while idle;
  - releases the pool after a settle delay once a job is loaded;
  - captures the first winning {match_flags, nonce};
  - detects nonce-space exhaustion with a cycle watchdog.
- Presents the captured result and the READY flag to the external IO block for daisy-chain readout.

Parameters:
- RESET_HOLD, 4, cycles the pool is held in reset after job_start before release (must be >=1).
- COUNT_WIDTH, 40, width of the run-cycle watchdog counter.
- MAX_CYCLES, 40'hFF_FFFF_FFFF, run cycles after which the job is declared exhausted (must be >=1 and < 2^COUNT_WIDTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- job_start  in  1  one-cycle pulse from external IO: new job/device config is loaded.
- result_ack  in  1  one-cycle pulse from external IO: result has been shifted out.
- success  in  1  pool success flag.
- nonce  in  32  pool winning nonce; valid when success=1.
- match_flags  in  8  pool per-hasher match flags; valid when success=1.
- core_reset_n  out  1  pool reset, active-low; registered.
- ready  out  1  result/exhaustion available; drives the open-drain READY pin upstream.
- found  out  1  result holds a valid winning nonce.
- exhausted  out  1  job ended with no success.
- result  out  40  {match_flags, nonce} captured on success.
- run_count  out  COUNT_WIDTH  cycles spent in RUN for the current or last job.

Behaviour:
- Reset (reset=1 at an edge), effective next cycle:
  - state=IDLE;
  - core_reset_n=0, ready=0, found=0, exhausted=0;
  - result=0, run_count=0, hold counter=0.
  - Reset takes effect from any state, including mid-RUN.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, PRIME, RUN, DONE.
- IDLE:
  - core_reset_n=0, ready=0.
  - job_start -> PRIME: clear found/exhausted/run_count/result; load hold counter with RESET_HOLD-1.
  - result_ack and success are ignored.
- PRIME:
  - core_reset_n=0.
  - Hold counter decrements each cycle.
  - When the counter is 0 -> RUN, and core_reset_n=1 from the next cycle.
  - Release occurs exactly RESET_HOLD cycles after the job_start cycle.
  - success is ignored.
- RUN:
  - core_reset_n=1.
  - run_count increments by 1 each RUN cycle; it saturates and never wraps.
  - success=1 -> DONE: result<={match_flags,nonce}, found=1, ready=1, core_reset_n=0, all visible the next cycle.
  - Otherwise, if run_count==MAX_CYCLES-1 -> DONE: exhausted=1, ready=1, core_reset_n=0.
  - success and exhaustion in the same cycle: success wins (found=1, exhausted=0, result captured).
- DONE:
  - core_reset_n=0, ready=1.
  - result, found, exhausted and run_count are held stable.
  - Further success is ignored; the first result is kept.
  - result_ack -> IDLE: ready=0 next cycle; result/found/exhausted/run_count are retained until the next job_start.
- job_start in any state other than IDLE:
  - Restarts the job: -> PRIME with the same clears; core_reset_n=0 next cycle.
  - job_start has priority over result_ack and over success in the same cycle.
- Invariant: ready=1 implies exactly one of found/exhausted is 1, and core_reset_n=0.

Test Plan:
- Reset held 3 cycles then released, no stimulus -> core_reset_n=0, ready=0, found=0, exhausted=0, result=0 on every cycle.
- job_start at cycle T, RESET_HOLD=4 -> core_reset_n=0 through T+4, core_reset_n=1 at T+5; run_count=1 at T+6.
- In RUN, success=1 with nonce=32'hDEADBEEF, match_flags=8'h02 for one cycle, then success=1 with nonce=32'h12345678 -> result=40'h02DEADBEEF, found=1, ready=1, core_reset_n=0 one cycle after the first success; the second success is ignored.
- MAX_CYCLES=16, no success -> DONE after 16 RUN cycles: exhausted=1, found=0, ready=1, run_count=15.
- MAX_CYCLES=16, success on the 16th RUN cycle -> found=1, exhausted=0, result captured.
- In DONE, result_ack -> ready=0 next cycle, result unchanged. job_start and result_ack in the same DONE cycle -> PRIME, found=0, result=0, ready=0.
- reset asserted mid-RUN (run_count=7) -> IDLE next cycle, core_reset_n=0, run_count=0; a later success without job_start has no effect.
